// File: rtl/mem_pkg.sv
// mem_pkg: op encodings, arbiter FSM states and default widths shared by the
// mem_arbiter slice.
package mem_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int RD_LAT_DEF = 1;

  localparam logic [1:0] MEM_NOP   = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } arb_state_e;

  // Reserved op 11 is never forwarded to the ram.
  function automatic logic [1:0] issue_op(input logic [1:0] op);
    return (op == MEM_READ || op == MEM_WRITE) ? op : MEM_NOP;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational 2-way picker with one-hot grant. Ties go to port 0,
// or, with MEM_ARB_RR_EN defined, to the port that was not granted last.
module arb_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) gnt_o = last_i ? 2'b01 : 2'b10;
    else if (req_i[0])  gnt_o = 2'b01;
    else if (req_i[1])  gnt_o = 2'b10;
  end
`else
  logic unused_last;
  assign unused_last = last_i;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0])      gnt_o = 2'b01;
    else if (req_i[1]) gnt_o = 2'b10;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported ram between two requesters, one access per
// grant (IDLE->ISSUE->[WAIT]->DONE). Define MEM_ARB_RR_EN for round-robin ties.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [1:0]        m0_op,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [1:0]        m1_op,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_bytes,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_e        state_q;
  logic [1:0]        gnt_q, done_q;
  logic              win_q;
  logic [1:0]        op_q, mem_op_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, rdata0_q, rdata1_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [1:0]        pick_d, op_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              last_w;

`ifdef MEM_ARB_RR_EN
  logic last_q;
  assign last_w = last_q;
`else
  assign last_w = 1'b1;
`endif

  arb_pick u_pick (
    .req_i  ({m1_req, m0_req}),
    .last_i (last_w),
    .gnt_o  (pick_d)
  );

  assign op_d    = pick_d[1] ? m1_op    : m0_op;
  assign addr_d  = pick_d[1] ? m1_addr  : m0_addr;
  assign wdata_d = pick_d[1] ? m1_wdata : m0_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      win_q       <= 1'b0;
      op_q        <= MEM_NOP;
      mem_op_q    <= MEM_NOP;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      cnt_q       <= '0;
`ifdef MEM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      done_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (|pick_d) begin
            state_q     <= ISSUE;
            gnt_q       <= pick_d;
            win_q       <= pick_d[1];
            op_q        <= op_d;
            mem_op_q    <= issue_op(op_d);
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
`ifdef MEM_ARB_RR_EN
            last_q      <= pick_d[1];
`endif
          end
        end
        ISSUE: begin
          mem_op_q <= MEM_NOP;
          if (op_q == MEM_READ) begin
            state_q <= WAIT;
            cnt_q   <= CNT_W'(RD_LAT - 1);
          end else begin
            state_q <= DONE;
            done_q  <= gnt_q;
          end
        end
        WAIT: begin
          // mem_data is valid on the edge where the countdown reaches zero.
          if (cnt_q == '0) begin
            state_q <= DONE;
            done_q  <= gnt_q;
            if (win_q) rdata1_q <= mem_data;
            else       rdata0_q <= mem_data;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_gnt          = gnt_q[0];
  assign m1_gnt          = gnt_q[1];
  assign m0_done         = done_q[0];
  assign m1_done         = done_q[1];
  assign m0_rdata        = rdata0_q;
  assign m1_rdata        = rdata1_q;
  assign mem_op          = mem_op_q;
  assign mem_addr        = mem_addr_q;
  assign mem_write_bytes = mem_wdata_q;
  assign busy            = (state_q != IDLE);

endmodule
